// File: rtl/z8086_video_pkg.sv
// Shared text-mode geometry, blitter opcodes and FSM state encodings for the VRAM blitter.
package z8086_video_pkg;
  localparam int TEXT_COLS    = 80;
  localparam int TEXT_ROWS    = 30;
  localparam int ADDR_W       = 12;
  localparam int SCREEN_WORDS = TEXT_COLS * TEXT_ROWS;

  localparam logic [15:0] DEFAULT_FILL = 16'h0720;

  typedef enum logic [1:0] {
    OP_NOP         = 2'd0,
    OP_FILL        = 2'd1,
    OP_SCROLL_UP   = 2'd2,
    OP_SCROLL_DOWN = 2'd3
  } blit_op_t;

  typedef logic [2:0] blit_state_t;

  localparam blit_state_t ST_IDLE = 3'd0;
  localparam blit_state_t ST_RD   = 3'd1;
  localparam blit_state_t ST_WR   = 3'd2;
  localparam blit_state_t ST_FILL = 3'd3;
  localparam blit_state_t ST_DONE = 3'd4;
endpackage

// File: rtl/z8086_blit_addr_gen.sv
// Destination/source word counters for blitter copies and fills, with end-of-phase detection.
module z8086_blit_addr_gen
  import z8086_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step,
  input  logic              up,
  input  logic [4:0]        rows,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] src,
  output logic              copy_last,
  output logic              fill_last
);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(SCREEN_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [ADDR_W-1:0] offset;
  logic              dir_up;

  // offset = rows * TEXT_COLS, computed once per operation as (rows<<6)+(rows<<4)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst    <= '0;
      offset <= '0;
      dir_up <= 1'b1;
    end else if (start) begin
      offset <= (ADDR_W'(rows) << 6) + (ADDR_W'(rows) << 4);
      dir_up <= up;
      dst    <= up ? '0 : LAST_WORD;
    end else if (step) begin
      dst <= dir_up ? dst + ONE : dst - ONE;
    end
  end

  // The fill phase simply continues the destination walk past the last copied word.
  assign src       = dir_up ? dst + offset : dst - offset;
  assign copy_last = dir_up ? (dst == LAST_WORD - offset) : (dst == offset);
  assign fill_last = dir_up ? (dst == LAST_WORD) : (dst == '0);
endmodule

// File: rtl/z8086_vram_blitter.sv
// Text-screen blitter in front of the video buffer VRAM port: CPU pass-through when idle,
// fill and scroll operations executed on VRAM itself while the CPU is stalled.
module z8086_vram_blitter
  import z8086_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ready,
  input  logic [1:0]        cmd_addr,
  input  logic              cmd_rd,
  input  logic              cmd_wr,
  input  logic [15:0]       cmd_din,
  output logic [15:0]       cmd_dout,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_din,
  output logic              vram_rd,
  output logic              vram_wr,
  input  logic [15:0]       vram_dout,
  output logic              done_irq
);
  blit_state_t       state;
  logic [15:0]       fill_reg;
  logic [15:0]       fill_word;
  logic [15:0]       last_cmd;
  logic              overrun;
  logic              busy;
  blit_op_t          cmd_op;
  logic [4:0]        cmd_rows;
  logic              cmd_go;
  logic              go_fill;
  logic              go_done;
  logic              ag_step;
  logic              ag_up;
  logic [4:0]        ag_rows;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] src;
  logic              copy_last;
  logic              fill_last;

  assign cmd_op   = blit_op_t'(cmd_din[1:0]);
  assign cmd_rows = cmd_din[8:4];
  assign cmd_go   = cmd_wr && (cmd_addr == 2'd1) && (state == ST_IDLE) && (cmd_op != OP_NOP);

  // Full-screen fill is a scroll-up by TEXT_ROWS rows: zero copies, every word filled.
  assign go_fill  = (cmd_op == OP_FILL) || (cmd_rows >= 5'(TEXT_ROWS));
  assign go_done  = !go_fill && (cmd_rows == 5'd0);
  assign ag_up    = go_fill || (cmd_op == OP_SCROLL_UP);
  assign ag_rows  = go_fill ? 5'(TEXT_ROWS) : cmd_rows;
  assign ag_step  = (state == ST_WR) || ((state == ST_FILL) && !fill_last);

  assign busy     = (state == ST_RD) || (state == ST_WR) || (state == ST_FILL);
  assign done_irq = (state == ST_DONE);
  assign cpu_dout = vram_dout;

  z8086_blit_addr_gen u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (cmd_go),
    .step      (ag_step),
    .up        (ag_up),
    .rows      (ag_rows),
    .dst       (dst),
    .src       (src),
    .copy_last (copy_last),
    .fill_last (fill_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cmd_go) state <= go_done ? ST_DONE : (go_fill ? ST_FILL : ST_RD);
        ST_RD:   state <= ST_WR;
        ST_WR:   state <= copy_last ? ST_FILL : ST_RD;
        ST_FILL: if (fill_last) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new overrun takes priority over the clear-on-read of the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_reg  <= DEFAULT_FILL;
      fill_word <= DEFAULT_FILL;
      last_cmd  <= '0;
      overrun   <= 1'b0;
      cmd_dout  <= '0;
    end else begin
      if (cmd_wr && (cmd_addr == 2'd0)) fill_reg <= cmd_din;
      if (cmd_go) begin
        fill_word <= fill_reg;
        last_cmd  <= cmd_din;
      end
      if (cmd_wr && (cmd_addr == 2'd1) && (state != ST_IDLE)) overrun <= 1'b1;
      else if (cmd_rd && (cmd_addr == 2'd2))                 overrun <= 1'b0;
      if (cmd_rd) begin
        case (cmd_addr)
          2'd0:    cmd_dout <= fill_reg;
          2'd1:    cmd_dout <= last_cmd;
          2'd2:    cmd_dout <= {14'b0, overrun, busy};
          default: cmd_dout <= '0;
        endcase
      end
    end
  end

  always_comb begin
    vram_addr = cpu_addr;
    vram_din  = cpu_din;
    vram_rd   = 1'b0;
    vram_wr   = 1'b0;
    cpu_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        vram_wr   = cpu_wr;
        vram_rd   = cpu_rd && !cpu_wr;
        cpu_ready = 1'b1;
      end
      ST_RD: begin
        vram_addr = src;
        vram_rd   = 1'b1;
      end
      ST_WR: begin
        vram_addr = dst;
        vram_din  = vram_dout;
        vram_wr   = 1'b1;
      end
      ST_FILL: begin
        vram_addr = dst;
        vram_din  = fill_word;
        vram_wr   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_z8086_vram_blitter.sv
// Directed bench for z8086_vram_blitter with a behavioural 1-cycle-latency VRAM model.
module tb_z8086_vram_blitter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_dout;
  logic        cpu_ready;
  logic [1:0]  cmd_addr;
  logic        cmd_rd;
  logic        cmd_wr;
  logic [15:0] cmd_din;
  logic [15:0] cmd_dout;
  logic [11:0] vram_addr;
  logic [15:0] vram_din;
  logic        vram_rd;
  logic        vram_wr;
  logic [15:0] vram_dout;
  logic        done_irq;

  logic [15:0] mem [0:4095];
  int          cyc = 0;
  int          irq_count = 0;
  int          bad_access = 0;
  int          checks = 0;
  int          fails = 0;

  z8086_vram_blitter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .cmd_addr(cmd_addr), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_din(cmd_din), .cmd_dout(cmd_dout),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_dout(vram_dout), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vram_wr) mem[vram_addr] <= vram_din;
    if (vram_rd) vram_dout <= mem[vram_addr];
    if ((vram_wr || vram_rd) && vram_addr > 12'd2399) bad_access <= bad_access + 1;
  end

  always @(negedge clk) if (done_irq) irq_count <= irq_count + 1;

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk); cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    @(negedge clk); cpu_wr = 1'b0;
  endtask

  task automatic preload_identity();
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk); cpu_addr = 12'(i); cpu_din = 16'(i); cpu_wr = 1'b1;
    end
    @(negedge clk); cpu_wr = 1'b0;
  endtask

  task automatic cmd_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk); cmd_addr = a; cmd_din = d; cmd_wr = 1'b1;
    @(negedge clk); cmd_wr = 1'b0;
  endtask

  task automatic cmd_read(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk); cmd_addr = a; cmd_rd = 1'b1;
    @(negedge clk); cmd_rd = 1'b0; #1 v = cmd_dout;
  endtask

  task automatic wait_done(input int t0, output int cycles);
    int guard = 0;
    while (!done_irq && guard < 10000) begin
      @(negedge clk); guard++;
    end
    cycles = cyc - t0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    @(negedge clk); #1;
    checks++; if (cpu_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", cpu_ready); end
    checks++; if (done_irq !== 1'b0) begin fails++; $display("[TB] FAIL reset_irq: got %b expected 0", done_irq); end
    checks++; if (cmd_dout !== 16'h0000) begin fails++; $display("[TB] FAIL reset_cmd_dout: got %h expected 0000", cmd_dout); end
    @(negedge clk); reset_n = 1'b1;
    cmd_read(2'd2, v);
    checks++; if (v !== 16'h0000) begin fails++; $display("[TB] FAIL reset_status: got %h expected 0000", v); end
    cmd_read(2'd0, v);
    checks++; if (v !== 16'h0720) begin fails++; $display("[TB] FAIL reset_fill: got %h expected 0720", v); end
  endtask

  task automatic test_cpu_passthrough();
    @(negedge clk); cpu_addr = 12'd5; cpu_din = 16'h0041; cpu_wr = 1'b1; #1;
    checks++; if ({vram_wr, vram_addr, vram_din, cpu_ready} !== {1'b1, 12'd5, 16'h0041, 1'b1}) begin
      fails++; $display("[TB] FAIL pass_wr: got wr=%b addr=%0d din=%h rdy=%b expected 1 5 0041 1", vram_wr, vram_addr, vram_din, cpu_ready);
    end
    @(negedge clk); cpu_wr = 1'b0; cpu_rd = 1'b1; #1;
    checks++; if ({vram_rd, vram_wr, cpu_ready} !== 3'b101) begin
      fails++; $display("[TB] FAIL pass_rd: got rd=%b wr=%b rdy=%b expected 1 0 1", vram_rd, vram_wr, cpu_ready);
    end
    @(negedge clk); cpu_rd = 1'b0; #1;
    checks++; if (cpu_dout !== 16'h0041) begin fails++; $display("[TB] FAIL pass_rdata: got %h expected 0041", cpu_dout); end
  endtask

  task automatic test_fill();
    int t0, cycles, errs, irq0;
    cmd_write(2'd0, 16'h1F20);
    irq0 = irq_count;
    cmd_write(2'd1, 16'h0001);
    t0 = cyc;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_stall: got ready=%b expected 0", cpu_ready); end
    wait_done(t0, cycles);
    checks++; if (cycles != 2400) begin fails++; $display("[TB] FAIL fill_cycles: got %0d expected 2400", cycles); end
    @(negedge clk); #1;
    checks++; if ({done_irq, cpu_ready} !== 2'b01) begin fails++; $display("[TB] FAIL fill_after: got irq=%b rdy=%b expected 0 1", done_irq, cpu_ready); end
    checks++; if (irq_count - irq0 != 1) begin fails++; $display("[TB] FAIL fill_irq_pulses: got %0d expected 1", irq_count - irq0); end
    errs = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== 16'h1F20) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL fill_contents: got %0d bad words expected 0", errs); end
  endtask

  task automatic test_scroll_up();
    int t0, cycles, errs;
    preload_identity();
    cmd_write(2'd0, 16'h0720);
    cmd_write(2'd1, 16'h0012);
    t0 = cyc;
    wait_done(t0, cycles);
    checks++; if (cycles != 4720) begin fails++; $display("[TB] FAIL up_cycles: got %0d expected 4720", cycles); end
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 2320; i++) if (mem[i] !== 16'(i + 80)) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL up_copy: got %0d bad words expected 0", errs); end
    errs = 0;
    for (int i = 2320; i < 2400; i++) if (mem[i] !== 16'h0720) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL up_fill: got %0d bad words expected 0", errs); end
  endtask

  task automatic test_scroll_down();
    int t0, cycles, errs, stall_errs;
    preload_identity();
    cmd_write(2'd0, 16'h0F2E);
    cmd_write(2'd1, 16'h0023);
    cpu_addr = 12'd7; cpu_din = 16'hBEEF; cpu_wr = 1'b1;
    t0 = cyc;
    stall_errs = 0;
    while (!done_irq && (cyc - t0) < 10000) begin
      #1 if (cpu_ready !== 1'b0) stall_errs++;
      @(negedge clk);
    end
    cycles = cyc - t0;
    checks++; if (cycles != 4640) begin fails++; $display("[TB] FAIL down_cycles: got %0d expected 4640", cycles); end
    checks++; if (stall_errs != 0) begin fails++; $display("[TB] FAIL down_stall: got %0d ready cycles expected 0", stall_errs); end
    #1;
    checks++; if (cpu_ready !== 1'b0) begin fails++; $display("[TB] FAIL down_done_ready: got %b expected 0", cpu_ready); end
    @(negedge clk); #1;
    checks++; if ({cpu_ready, vram_wr, vram_addr} !== {1'b1, 1'b1, 12'd7}) begin
      fails++; $display("[TB] FAIL down_cpu_land: got rdy=%b wr=%b addr=%0d expected 1 1 7", cpu_ready, vram_wr, vram_addr);
    end
    @(negedge clk); cpu_wr = 1'b0;
    errs = 0;
    for (int i = 160; i < 2400; i++) if (mem[i] !== 16'(i - 160)) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL down_copy: got %0d bad words expected 0", errs); end
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[i] !== ((i == 7) ? 16'hBEEF : 16'h0F2E)) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL down_fill: got %0d bad words expected 0", errs); end
  endtask

  task automatic test_overrun();
    int t0, cycles, errs;
    logic [15:0] v;
    cmd_write(2'd0, 16'h5555);
    cmd_write(2'd1, 16'h0001);
    t0 = cyc;
    cmd_write(2'd1, 16'h0012);
    cmd_write(2'd0, 16'h1234);
    cmd_read(2'd2, v);
    checks++; if (v !== 16'h0003) begin fails++; $display("[TB] FAIL ovr_status1: got %h expected 0003", v); end
    cmd_read(2'd2, v);
    checks++; if (v !== 16'h0001) begin fails++; $display("[TB] FAIL ovr_status2: got %h expected 0001", v); end
    wait_done(t0, cycles);
    checks++; if (cycles != 2400) begin fails++; $display("[TB] FAIL ovr_cycles: got %0d expected 2400", cycles); end
    cmd_read(2'd2, v);
    checks++; if (v !== 16'h0000) begin fails++; $display("[TB] FAIL ovr_status3: got %h expected 0000", v); end
    errs = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== 16'h5555) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL ovr_contents: got %0d bad words expected 0", errs); end
  endtask

  task automatic test_nop_and_limits();
    int t0, cycles, errs, irq0;
    irq0 = irq_count;
    cmd_write(2'd1, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({cpu_ready, done_irq} !== 2'b10) begin fails++; $display("[TB] FAIL nop_state: got rdy=%b irq=%b expected 1 0", cpu_ready, done_irq); end
    checks++; if (irq_count != irq0) begin fails++; $display("[TB] FAIL nop_irq: got %0d pulses expected 0", irq_count - irq0); end
    cmd_write(2'd1, 16'h0002);
    #1;
    checks++; if ({done_irq, cpu_ready} !== 2'b10) begin fails++; $display("[TB] FAIL n0_done: got irq=%b rdy=%b expected 1 0", done_irq, cpu_ready); end
    @(negedge clk); #1;
    checks++; if (cpu_ready !== 1'b1) begin fails++; $display("[TB] FAIL n0_ready: got %b expected 1", cpu_ready); end
    errs = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== 16'h5555) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL n0_contents: got %0d changed words expected 0", errs); end
    cmd_write(2'd1, 16'h01F3);
    t0 = cyc;
    wait_done(t0, cycles);
    checks++; if (cycles != 2400) begin fails++; $display("[TB] FAIL n31_cycles: got %0d expected 2400", cycles); end
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== 16'h1234) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL n31_contents: got %0d bad words expected 0", errs); end
  endtask

  task automatic test_reset_mid_op();
    int errs;
    logic [15:0] v;
    preload_identity();
    cmd_write(2'd1, 16'h0012);
    repeat (201) @(negedge clk);
    #1;
    checks++; if ({vram_wr, vram_addr} !== {1'b1, 12'd100}) begin
      fails++; $display("[TB] FAIL mid_position: got wr=%b addr=%0d expected 1 100", vram_wr, vram_addr);
    end
    reset_n = 1'b0; #1;
    checks++; if ({vram_wr, cpu_ready, done_irq} !== 3'b010) begin
      fails++; $display("[TB] FAIL mid_abort: got wr=%b rdy=%b irq=%b expected 0 1 0", vram_wr, cpu_ready, done_irq);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    errs = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== 16'(i + 80)) errs++;
    for (int i = 101; i < 2400; i++) if (mem[i] !== 16'(i)) errs++;
    checks++; if (errs != 0) begin fails++; $display("[TB] FAIL mid_contents: got %0d bad words expected 0", errs); end
    cmd_read(2'd0, v);
    checks++; if (v !== 16'h0720) begin fails++; $display("[TB] FAIL mid_fill_reset: got %h expected 0720", v); end
    cmd_read(2'd2, v);
    checks++; if (v !== 16'h0000) begin fails++; $display("[TB] FAIL mid_status: got %h expected 0000", v); end
  endtask

  initial begin
    reset_n  = 1'b0;
    cpu_addr = '0; cpu_din = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cmd_addr = '0; cmd_din = '0; cmd_rd = 1'b0; cmd_wr = 1'b0;
    vram_dout = '0;
    $display("[TB] starting z8086_vram_blitter bench");
    test_reset();
    test_cpu_passthrough();
    test_fill();
    test_scroll_up();
    test_scroll_down();
    test_overrun();
    test_nop_and_limits();
    test_reset_mid_op();
    checks++; if (bad_access != 0) begin fails++; $display("[TB] FAIL range: got %0d out-of-range accesses expected 0", bad_access); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
